// File: rtl/sqrt_sched_pkg.sv
// sqrt_sched_pkg: shared FSM states, channel-tag width helper and watchdog default for the sqrt scheduler
package sqrt_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int TIMEOUT_DEFAULT = 64;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sqrt_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first requester at or after ptr wins, wrapping to the lowest index
module rr_arbiter
  import sqrt_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_w(N_CH)
)(
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            any
);
  logic [CH_W-1:0] idx_hi, idx_lo;
  logic hi;
  always_comb begin
    hi = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[k]) idx_lo = CH_W'(k);
      if (req[k] && CH_W'(k) >= ptr) begin
        idx_hi = CH_W'(k);
        hi = 1'b1;
      end
    end
  end
  assign grant_idx = hi ? idx_hi : idx_lo;
  assign any = |req;
  assign grant = any ? N_CH'(1) << grant_idx : '0;
endmodule

// File: rtl/sqrt_rr_scheduler.sv
// sqrt_rr_scheduler: round-robin share of one iterative sqrt core among N_CH channels; SQRT_SCHED_TIMEOUT_EN adds a WAIT watchdog
module sqrt_rr_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int inout_width = 16,
`ifdef SQRT_SCHED_TIMEOUT_EN
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
`endif
  localparam int CH_W = ch_w(N_CH)
)(
  input  logic                          aclk,
  input  logic                          reset,
  input  logic [N_CH*2*inout_width-1:0] s_radicand,
  input  logic [N_CH-1:0]               s_valid,
  output logic [N_CH-1:0]               s_ready,
  output logic [2*inout_width-1:0]      core_radicand,
  output logic                          core_i_data_valid,
  input  logic [inout_width-1:0]        core_root,
  input  logic                          core_o_data_valid,
  input  logic                          core_error_value0,
  output logic [inout_width-1:0]        m_root,
  output logic [CH_W-1:0]               m_ch,
  output logic                          m_valid,
  output logic                          m_error,
  output logic                          busy
);
  localparam int RW = 2 * inout_width;
  state_t state, nxt;
  logic [CH_W-1:0] rr_ptr, cur_ch, grant_idx;
  logic [N_CH-1:0] grant;
  logic [RW-1:0] rad_arr [N_CH];
  logic any, timeout_hit, fire, accept;
  for (genvar g = 0; g < N_CH; g++) begin : g_rad
    assign rad_arr[g] = s_radicand[g*RW +: RW];
  end
  rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .req(s_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .grant_idx(grant_idx),
    .any(any)
  );
  assign accept = state == IDLE && any;
  assign s_ready = state == IDLE ? grant : '0;
  assign busy = state != IDLE;
  assign fire = state == WAIT && (core_o_data_valid || timeout_hit);
`ifdef SQRT_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt;
  always_ff @(posedge aclk or posedge reset)
    if (reset) wd_cnt <= '0;
    else wd_cnt <= state == WAIT ? wd_cnt + 16'd1 : '0;
  assign timeout_hit = wd_cnt == 16'(TIMEOUT - 1);
`else
  assign timeout_hit = 1'b0;
`endif
  always_ff @(posedge aclk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (any ? ISSUE : IDLE) :
          state == ISSUE ? WAIT :
          state == WAIT  ? (fire ? DONE : WAIT) : IDLE;
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      cur_ch <= '0;
      core_radicand <= '0;
      core_i_data_valid <= 1'b0;
      m_root <= '0;
      m_ch <= '0;
      m_valid <= 1'b0;
      m_error <= 1'b0;
    end else begin
      core_i_data_valid <= accept;
      m_valid <= fire;
      if (accept) begin
        core_radicand <= rad_arr[grant_idx];
        cur_ch <= grant_idx;
        rr_ptr <= grant_idx == CH_W'(N_CH - 1) ? '0 : grant_idx + 1'b1;
      end
      if (fire) begin
        m_root <= core_o_data_valid ? core_root : '0;
        m_ch <= cur_ch;
        m_error <= core_o_data_valid ? core_error_value0 : 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// tb_sqrt_rr_scheduler: transaction-level model of the shared sqrt scheduler with a stub core and randomized traffic
module tb_sqrt_rr_scheduler;
  localparam int N = 4, W = 16, RW = 32;
  logic aclk = 1'b0, reset = 1'b1;
  logic [N*RW-1:0] s_radicand = '0;
  logic [N-1:0] s_valid = '0, s_ready;
  logic [RW-1:0] core_radicand;
  logic core_i_data_valid, core_o_data_valid = 1'b0, core_error_value0 = 1'b0;
  logic [W-1:0] core_root = '0, m_root;
  logic [1:0] m_ch;
  logic m_valid, m_error, busy;
  sqrt_rr_scheduler #(.N_CH(N), .inout_width(W)) dut (
    .aclk(aclk), .reset(reset), .s_radicand(s_radicand), .s_valid(s_valid), .s_ready(s_ready),
    .core_radicand(core_radicand), .core_i_data_valid(core_i_data_valid), .core_root(core_root),
    .core_o_data_valid(core_o_data_valid), .core_error_value0(core_error_value0),
    .m_root(m_root), .m_ch(m_ch), .m_valid(m_valid), .m_error(m_error), .busy(busy)
  );
  always #5 aclk = ~aclk;
  int errors = 0, checks = 0, cyc = 0;
  bit [N-1:0] pend = '0, hold = '0;
  logic [RW-1:0] rad [N];
  bit rnd_mode = 0, rnd_err = 0, real_done = 0;
  int lat_fix = 0, stub_done_at = -1;
  logic [RW-1:0] stub_rad = '0;
  logic stub_err = 1'b0;
  bit inflight = 0;
  int free_at = 0, m_ptr = 0, start_at = -1, mval_at = -1, cur_ch = 0;
  logic [RW-1:0] cur_rad = '0;
  logic exp_err = 1'b0;
  int got_ch[$], got_cyc[$], grants[$];
  logic [W-1:0] got_root[$];
  logic got_err[$];
  int civ_cnt = 0, first_r2 = -1;
  function automatic logic [W-1:0] isqrt(input logic [RW-1:0] x);
    longint r = 0;
    for (int b = W - 1; b >= 0; b--)
      if ((r + (longint'(1) << b)) * (r + (longint'(1) << b)) <= longint'(x)) r += longint'(1) << b;
    return W'(r);
  endfunction
  function automatic logic [RW-1:0] pick_rad();
    int s = $urandom_range(0, 3);
    return s == 0 ? '0 : s == 1 ? '1 : RW'($urandom);
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask
  task automatic step();
    logic [N-1:0] er;
    bit idle;
    int w;
    @(negedge aclk);
    cyc++;
    real_done = 0;
    core_o_data_valid = 1'b0;
    if (stub_done_at == cyc) begin
      core_o_data_valid = 1'b1;
      core_root = isqrt(stub_rad);
      core_error_value0 = stub_err;
      stub_done_at = -1;
      real_done = 1;
    end else if (rnd_mode && stub_done_at < 0 && $urandom_range(0, 9) == 0) begin
      core_o_data_valid = 1'b1;
      core_root = W'($urandom);
      core_error_value0 = 1'($urandom);
    end
    for (int k = 0; k < N; k++) begin
      if (rnd_mode && !pend[k] && $urandom_range(0, 3) == 0) begin
        pend[k] = 1'b1;
        rad[k] = pick_rad();
      end else if (rnd_mode && pend[k] && !hold[k] && $urandom_range(0, 15) == 0) pend[k] = 1'b0;
      s_radicand[k*RW +: RW] = rad[k];
    end
    s_valid = pend;
    #1;
    if (core_i_data_valid) begin
      civ_cnt++;
      stub_rad = core_radicand;
      stub_err = rnd_err ? 1'($urandom) : 1'b0;
      stub_done_at = cyc + (lat_fix > 0 ? lat_fix : int'($urandom_range(1, 6)));
    end
    for (int k = 0; k < N; k++) if (s_ready[k] && s_valid[k]) grants.push_back(k);
    if (s_ready[2] && first_r2 < 0) first_r2 = cyc;
    if (m_valid) begin
      got_ch.push_back(int'(m_ch));
      got_root.push_back(m_root);
      got_err.push_back(m_error);
      got_cyc.push_back(cyc);
    end
    idle = !inflight && cyc >= free_at;
    er = '0;
    if (idle && s_valid != '0) begin
      w = m_ptr;
      while (!s_valid[w]) w = (w + 1) % N;
      er[w] = 1'b1;
      inflight = 1;
      cur_ch = w;
      cur_rad = rad[w];
      start_at = cyc + 1;
      mval_at = -1;
      m_ptr = (w + 1) % N;
      if (!hold[w]) pend[w] = 1'b0;
    end
    if (inflight && real_done && cyc > start_at) begin
      mval_at = cyc + 1;
      exp_err = stub_err;
    end
    chk("s_ready", s_ready, er);
    chk("busy", busy, !idle);
    chk("core_start", core_i_data_valid, inflight && cyc == start_at);
    chk("m_valid", m_valid, cyc == mval_at);
    if (inflight && cyc >= start_at) chk("core_radicand", core_radicand, cur_rad);
    if (cyc == mval_at) begin
      chk("m_root", m_root, isqrt(cur_rad));
      chk("m_ch", m_ch, cur_ch);
      chk("m_error", m_error, exp_err);
      inflight = 0;
      free_at = cyc + 1;
    end
  endtask
  task automatic do_reset();
    @(negedge aclk);
    cyc++;
    reset = 1'b1;
    pend = '0;
    hold = '0;
    s_valid = '0;
    core_o_data_valid = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_core_radicand", core_radicand, 0);
    chk("rst_core_start", core_i_data_valid, 0);
    chk("rst_m_root", m_root, 0);
    chk("rst_m_ch", m_ch, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_error", m_error, 0);
    chk("rst_busy", busy, 0);
    inflight = 0;
    free_at = 0;
    m_ptr = 0;
    start_at = -1;
    mval_at = -1;
    stub_done_at = -1;
    repeat (2) begin
      @(negedge aclk);
      cyc++;
    end
    reset = 1'b0;
  endtask
  task automatic clr();
    got_ch.delete();
    got_root.delete();
    got_err.delete();
    got_cyc.delete();
    grants.delete();
    civ_cnt = 0;
    first_r2 = -1;
  endtask
  task automatic run_until(input int n, input int maxc);
    int i = 0;
    while (got_root.size() < n && i < maxc) begin
      step();
      i++;
    end
    chk("results_by_deadline", got_root.size(), n);
  endtask
  task automatic drain();
    int i = 0;
    while ((pend != '0 || inflight) && i < 1000) begin
      step();
      i++;
    end
    chk("drain", {pend != '0, inflight}, 0);
    repeat (3) step();
  endtask
  task automatic wait_stub(input int maxc);
    int i = 0;
    while (stub_done_at < 0 && i < maxc) begin
      step();
      i++;
    end
    chk("core_started", stub_done_at >= 0, 1);
  endtask
  initial begin
    int exp_root [4] = '{0, 256, 43, 65535};
    int fair [6] = '{3, 1, 3, 1, 3, 1};
    for (int k = 0; k < N; k++) rad[k] = '0;
    do_reset();
    clr();
    rad[0] = 1895;
    pend[0] = 1'b1;
    lat_fix = 3;
    run_until(1, 100);
    repeat (10) step();
    chk("t1_count", got_root.size(), 1);
    chk("t1_root", got_root[0], 43);
    chk("t1_ch", got_ch[0], 0);
    chk("t1_err", got_err[0], 0);
    chk("t1_grants", grants.size(), 1);
    chk("t1_starts", civ_cnt, 1);
    do_reset();
    clr();
    rad[0] = 0;
    rad[1] = 65536;
    rad[2] = 1895;
    rad[3] = 32'hFFFF_FFFF;
    pend = 4'hF;
    lat_fix = 0;
    run_until(4, 200);
    for (int i = 0; i < 4; i++) begin
      chk("t2_grant", grants[i], i);
      chk("t2_root", got_root[i], exp_root[i]);
      chk("t2_ch", got_ch[i], i);
    end
    drain();
    clr();
    rad[1] = 10000;
    pend[1] = 1'b1;
    run_until(1, 100);
    drain();
    clr();
    rad[1] = 400;
    rad[3] = 900;
    hold = 4'b1010;
    pend = 4'b1010;
    run_until(6, 300);
    hold = '0;
    drain();
    for (int i = 0; i < 6; i++) begin
      chk("t3_grant", grants[i], fair[i]);
      chk("t3_root", got_root[i], fair[i] == 3 ? 30 : 20);
    end
    clr();
    lat_fix = 8;
    rad[0] = 2500;
    pend[0] = 1'b1;
    wait_stub(50);
    rad[2] = 144;
    pend[2] = 1'b1;
    run_until(2, 200);
    drain();
    chk("t4_ready2_cycle", first_r2, got_cyc[0] + 1);
    chk("t4_starts", civ_cnt, 2);
    chk("t4_root2", got_root[1], 12);
    chk("t4_ch2", got_ch[1], 2);
    clr();
    lat_fix = 30;
    rad[1] = 50000;
    pend[1] = 1'b1;
    wait_stub(50);
    repeat (5) step();
    do_reset();
    repeat (40) step();
    chk("t5_no_result", got_root.size(), 0);
    rad[1] = 100;
    pend[1] = 1'b1;
    lat_fix = 4;
    run_until(1, 100);
    chk("t5_root", got_root[0], 10);
    chk("t5_ch", got_ch[0], 1);
    clr();
    rnd_mode = 1;
    rnd_err = 1;
    lat_fix = 0;
    repeat (3000) step();
    rnd_mode = 0;
    drain();
    chk("t6_activity", got_root.size() > 100, 1);
    chk("t6_starts_vs_results", civ_cnt, got_root.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/sqrt_rr_scheduler.md
Name: sqrt_rr_scheduler

Overview:
- Shares one non-restoring square-root core (`non_restoring_sqrt_v1_0`, iterative, pulse-start/pulse-done) between N_CH requesters.
- Arbitration is round-robin.
- Sits between per-channel RMS mean-square stages and the single sqrt core.
- Returns each root tagged with its channel index.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- inout_width, 16, root width; radicand width is 2*inout_width.
- CH_W, $clog2(N_CH), channel-tag width (localparam).

Ports:
- aclk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_radicand  in  N_CH*2*inout_width  packed radicands, channel k at bits [k*2W +: 2W].
- s_valid  in  N_CH  per-channel request; held with data until accepted.
- s_ready  out  N_CH  one-hot grant; transfer occurs when s_valid[k] & s_ready[k].
- core_radicand  out  2*inout_width  operand to sqrt core.
- core_i_data_valid  out  1  one-cycle start pulse to core.
- core_root  in  inout_width  core result.
- core_o_data_valid  in  1  core done pulse.
- core_error_value0  in  1  core error flag, sampled with done.
- m_root  out  inout_width  result.
- m_ch  out  CH_W  channel tag of m_root.
- m_valid  out  1  one-cycle result strobe, no backpressure.
- m_error  out  1  error qualifier, valid when m_valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (async assert, sync release): state=IDLE, rr_ptr=0, core_radicand=0, core_i_data_valid=0, m_root=0, m_ch=0, m_valid=0, m_error=0, s_ready=0, busy=0.
- State machine, four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Grant = first k with s_valid[k]=1, searching k = rr_ptr, rr_ptr+1, … modulo N_CH.
  - s_ready is combinational: one-hot grant while state==IDLE, else 0.
  - On an edge with a grant: latch s_radicand[k] into core_radicand, latch k into cur_ch, set rr_ptr=(k+1) mod N_CH, go to ISSUE.
  - No s_valid: stay in IDLE.
- ISSUE: core_i_data_valid=1 (registered, exactly one cycle); go to WAIT.
- WAIT:
  - Hold core_radicand stable.
  - On core_o_data_valid=1: latch m_root=core_root, m_ch=cur_ch, m_error=core_error_value0; go to DONE.
- DONE: m_valid=1 for exactly one cycle; go to IDLE.
- Latency: accept edge to m_valid = core latency + 3 cycles.
- Throughput: one request per core latency + 3 cycles.
- Fairness: a continuously requesting channel waits at most N_CH-1 services.
- s_valid dropped before grant: no transfer, no side effects.
- core_o_data_valid outside WAIT is ignored.
- Simultaneous events:
  - Several s_valid in the same cycle: only the round-robin winner gets s_ready.
  - A new s_valid during WAIT or DONE is granted no earlier than the next IDLE cycle.
- Reset mid-operation: the FSM returns to IDLE immediately and no m_valid is produced for the in-flight request. The core must share the reset, so its pending result is discarded.
- Radicand 0 and all-ones are legal; values pass through unmodified.

Optional Feature:
- Macro: SQRT_SCHED_TIMEOUT_EN.
- Defined:
  - Adds a parameter TIMEOUT (default 64) and a 16-bit watchdog counter.
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without core_o_data_valid: go to DONE with m_root=0, m_error=1, m_ch=cur_ch.
- Not defined: WAIT blocks indefinitely until core_o_data_valid; no counter logic is synthesised.

Decomposition:
- Package sqrt_sched_pkg holds:
  - enum state_t {IDLE, ISSUE, WAIT, DONE}, 2-bit;
  - localparam function for CH_W;
  - TIMEOUT default constant.
- One natural sub-module, rr_arbiter:
  - Combinational priority search from rr_ptr.
  - Inputs req[N_CH], ptr[CH_W]; outputs grant one-hot[N_CH], grant_idx[CH_W], any.
  - Instantiated once; reusable elsewhere in the design.

Test Plan:
- Single request: ch0 radicand 1895 -> one s_ready[0] pulse; m_root=43, m_ch=0, m_error=0, single m_valid.
- All four channels valid together, radicands 0, 65536, 1895, 4294967295 -> grants in order 0,1,2,3; results 0, 256, 43, 65535 tagged 0..3.
- Fairness: ch1 and ch3 held continuously valid for 6 services, rr_ptr starting at 2 -> grant order 3,1,3,1,3,1; no starvation.
- Backlog: ch2 asserts s_valid during WAIT of ch0 -> s_ready[2] first asserts in the IDLE cycle after ch0's m_valid; core_i_data_valid pulses exactly once per request.
- Reset mid-WAIT: reset asserted 5 cycles after ch1's start pulse -> all outputs return to reset values at once, no m_valid; a fresh ch1 request of 100 after release returns 10.
- With SQRT_SCHED_TIMEOUT_EN, TIMEOUT=64, core done pulse suppressed -> m_valid occurs 64 cycles after WAIT entry with m_error=1, m_root=0; the next request is then served normally.
